// File: rtl/uart_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// uart_ctrl_pkg : shared types and helpers for the UART transmit scheduler
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } sched_state_t;

  // Default watchdog span in bit periods: roughly two full frames.
  localparam int TIMEOUT_MULT = 24;

  function automatic int uart_clkcount(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, first request after pointer
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   pointer,
  output logic [N-1:0] grant,
  output logic [2:0]   index,
  output logic         found
);

  logic       hit_hi;
  logic       hit_lo;
  logic [2:0] idx_hi;
  logic [2:0] idx_lo;

  // Scan downwards so the lowest index in each half wins; indices above the
  // pointer outrank the wrapped-around ones.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (3'(i) > pointer) begin
          hit_hi = 1'b1;
          idx_hi = 3'(i);
        end else begin
          hit_lo = 1'b1;
          idx_lo = 3'(i);
        end
      end
    end
    found = hit_hi | hit_lo;
    index = hit_hi ? idx_hi : idx_lo;
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = found && (index == 3'(i));
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// ----------------------------------------------------------------------------
// uart_tx_sched : round-robin sharing of one UART transmitter among requesters
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_sched
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600,
  parameter int TIMEOUT   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   done_pulse,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 timeout_err,
  output logic                 uart_newd,
  output logic [7:0]           uart_dintx,
  input  logic                 uart_tx,
  input  logic                 uart_donetx
);

  localparam int TO_LIMIT = (TIMEOUT == 0) ?
                            TIMEOUT_MULT * uart_clkcount(clk_freq, baud_rate) : TIMEOUT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("uart_tx_sched: NUM_REQ must be in 2..8");
    end
  endgenerate

  sched_state_t       state;
  logic [2:0]         rr_ptr;
  logic [NUM_REQ-1:0] grant_oh;
  logic [TO_W-1:0]    wd_cnt;
  logic               tx_meta, tx_sync;
  logic               done_meta, done_sync, done_prev;

  logic [NUM_REQ-1:0] arb_grant;
  logic [2:0]         arb_idx;
  logic               arb_found;
  logic [7:0]         sel_byte;
  logic               wd_hit;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .pointer (rr_ptr),
    .grant   (arb_grant),
    .index   (arb_idx),
    .found   (arb_found)
  );

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) sel_byte = req_data[8*i +: 8];
    end
  end

  assign wd_hit = (wd_cnt == TO_W'(TO_LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= 3'(NUM_REQ - 1);
      grant_oh    <= '0;
      wd_cnt      <= '0;
      tx_meta     <= 1'b1;
      tx_sync     <= 1'b1;
      done_meta   <= 1'b0;
      done_sync   <= 1'b0;
      done_prev   <= 1'b0;
      req_ready   <= '0;
      done_pulse  <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      uart_newd   <= 1'b0;
      uart_dintx  <= '0;
    end else begin
      // uart_tx / uart_donetx come from the UART's own clock domain.
      tx_meta    <= uart_tx;
      tx_sync    <= tx_meta;
      done_meta  <= uart_donetx;
      done_sync  <= done_meta;
      done_prev  <= done_sync;
      req_ready  <= '0;
      done_pulse <= '0;

      if (state == IDLE) begin
        if (arb_found) begin
          uart_dintx <= sel_byte;
          grant_id   <= arb_idx;
          grant_oh   <= arb_grant;
          req_ready  <= arb_grant;
          busy       <= 1'b1;
          wd_cnt     <= '0;
          state      <= LOAD;
        end
      end else if (wd_hit) begin
        timeout_err <= 1'b1;
        uart_newd   <= 1'b0;
        busy        <= 1'b0;
        rr_ptr      <= grant_id;
        state       <= IDLE;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
        case (state)
          LOAD: begin
            uart_newd <= 1'b1;
            state     <= WAIT_START;
          end
          // newd stays up until the start bit proves the UART accepted it.
          WAIT_START: begin
            if (!tx_sync) begin
              uart_newd <= 1'b0;
              state     <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            if (done_sync && !done_prev) begin
              done_pulse <= grant_oh;
              busy       <= 1'b0;
              rr_ptr     <= grant_id;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
